// File: rtl/bt_cmd_arbiter_pkg.sv
// Shared encodings for the Bluetooth/key command arbiter: owner states and
// the choice codes that carry a direction.
package bt_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_BT   = 2'b01,
        OWN_KEY  = 2'b10
    } owner_e;

    localparam int CHOICE_MAX = 4;

    localparam logic [2:0] CH_DIR_A = 3'd3;
    localparam logic [2:0] CH_DIR_B = 3'd4;

endpackage

// File: rtl/bt_cmd_arbiter_if.sv
// Command bus between the UART/key sources and the arbiter, plus the
// arbitrated dir/choice outputs toward the game core.
interface bt_cmd_arbiter_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_req;
    logic [1:0] key_dir;
    logic [2:0] key_choice;
    logic [1:0] dir;
    logic [2:0] choice;
    logic       cmd_valid;
    logic [1:0] owner;
    logic       bt_err;

    modport slave (
        input  rx_data, rx_valid, key_req, key_dir, key_choice,
        output dir, choice, cmd_valid, owner, bt_err
    );

    modport master (
        output rx_data, rx_valid, key_req, key_dir, key_choice,
        input  dir, choice, cmd_valid, owner, bt_err
    );
endinterface

// File: rtl/bt_cmd_arbiter_hold_timer.sv
// Bluetooth ownership hold timer: loadable down-counter that stops at zero
// and reports when it has reached it.
module bt_hold_timer #(
    parameter int TIMER_W = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bt_cmd_arbiter.sv
// Decodes Bluetooth command bytes, arbitrates the dir/choice bus between
// Bluetooth and the on-board keys, and registers the result with a change strobe.
module bt_cmd_arbiter #(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int TIMER_W    = 26,
    parameter int CHOICE_MAX = bt_cmd_arbiter_pkg::CHOICE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    bt_cmd_arbiter_if.slave   bus
);
    import bt_cmd_arbiter_pkg::*;

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(HOLD_CYC - 1);

    owner_e     r_state;
    owner_e     w_state_next;
    logic [1:0] r_dir;
    logic [1:0] w_dir_next;
    logic [2:0] r_choice;
    logic [2:0] w_choice_next;
    logic       r_cmd_valid;
    logic       r_bt_err;

    logic [2:0] w_bt_choice;
    logic [1:0] w_bt_dir;
    logic       w_bt_legal;
    logic       w_bt_cmd;
    logic       w_bt_bad;
    logic       w_tmr_load;
    logic       w_tmr_dec;
    logic       w_tmr_zero;

    assign w_bt_choice = bus.rx_data[6:4];
    assign w_bt_legal  = !bus.rx_data[7] && (int'(w_bt_choice) <= CHOICE_MAX);
    // Only the direction-bearing choice codes take d; all others force dir=00.
    assign w_bt_dir    = ((w_bt_choice == CH_DIR_A) || (w_bt_choice == CH_DIR_B))
                         ? {bus.rx_data[3], bus.rx_data[0]} : 2'b00;
    assign w_bt_cmd    = bus.rx_valid && w_bt_legal;
    assign w_bt_bad    = bus.rx_valid && !w_bt_legal;

    bt_hold_timer #(
        .TIMER_W (TIMER_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_next  = r_state;
        w_dir_next    = r_dir;
        w_choice_next = r_choice;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;

        // A rejected byte freezes the whole arbiter for that cycle.
        if (!w_bt_bad) begin
            if (w_bt_cmd) begin
                w_state_next  = OWN_BT;
                w_dir_next    = w_bt_dir;
                w_choice_next = w_bt_choice;
                w_tmr_load    = 1'b1;
            end else begin
                case (r_state)
                    OWN_IDLE: begin
                        if (bus.key_req) begin
                            w_state_next  = OWN_KEY;
                            w_dir_next    = bus.key_dir;
                            w_choice_next = bus.key_choice;
                        end
                    end
                    OWN_BT: begin
                        if (w_tmr_zero) begin
                            w_state_next = OWN_IDLE;
                        end else begin
                            w_tmr_dec = 1'b1;
                        end
                    end
                    OWN_KEY: begin
                        if (!bus.key_req) begin
                            w_state_next = OWN_IDLE;
                        end else begin
                            w_dir_next    = bus.key_dir;
                            w_choice_next = bus.key_choice;
                        end
                    end
                    default: w_state_next = OWN_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= OWN_IDLE;
            r_dir       <= 2'b00;
            r_choice    <= 3'b000;
            r_cmd_valid <= 1'b0;
            r_bt_err    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dir       <= w_dir_next;
            r_choice    <= w_choice_next;
            r_cmd_valid <= ({w_choice_next, w_dir_next} != {r_choice, r_dir});
            r_bt_err    <= w_bt_bad;
        end
    end

    assign bus.dir       = r_dir;
    assign bus.choice    = r_choice;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.owner     = r_state;
    assign bus.bt_err    = r_bt_err;

endmodule

// File: tb/tb_bt_cmd_arbiter.sv
// Directed bench for bt_cmd_arbiter: a scoreboard queue of expected strobes
// checked by a negedge monitor, plus direct owner/timing/reset checks.
module tb_bt_cmd_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    typedef struct {
        bit         is_err;
        logic [2:0] choice;
        logic [1:0] dir;
        logic [1:0] owner;
    } exp_t;

    exp_t exp_q[$];

    bt_cmd_arbiter_if bus ();

    bt_cmd_arbiter #(
        .HOLD_CYC   (8),
        .TIMER_W    (4),
        .CHOICE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s = %0h t=%0t", nm, act, $time);
        end
    endtask

    task automatic push(input bit e, input logic [2:0] c, input logic [1:0] d, input logic [1:0] o);
        exp_t x;
        x.is_err = e; x.choice = c; x.dir = d; x.owner = o;
        exp_q.push_back(x);
    endtask

    // Byte is sampled on the second posedge after the call; returns 1 ns after that edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && (bus.cmd_valid || bus.bt_err)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL strobe unexpected cmd_valid=%0b bt_err=%0b t=%0t",
                         bus.cmd_valid, bus.bt_err, $time);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if ({bus.cmd_valid, bus.bt_err, bus.choice, bus.dir, bus.owner} !==
                    {!x.is_err, x.is_err, x.choice, x.dir, x.owner}) begin
                    n_errors++;
                    $display("FAIL strobe got cv=%0b err=%0b ch=%0d dir=%b own=%b expected cv=%0b err=%0b ch=%0d dir=%b own=%b t=%0t",
                             bus.cmd_valid, bus.bt_err, bus.choice, bus.dir, bus.owner,
                             !x.is_err, x.is_err, x.choice, x.dir, x.owner, $time);
                end else begin
                    $display("ok   strobe cv=%0b err=%0b ch=%0d dir=%b own=%b t=%0t",
                             bus.cmd_valid, bus.bt_err, bus.choice, bus.dir, bus.owner, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.key_req = 1'b0;  bus.key_dir = 2'b00; bus.key_choice = 3'd0;
        cycles(3);
        chk("rst_dir", {6'd0, bus.dir}, 8'h0);
        chk("rst_choice", {5'd0, bus.choice}, 8'h0);
        chk("rst_owner", {6'd0, bus.owner}, 8'h0);
        chk("rst_strobes", {6'd0, bus.cmd_valid, bus.bt_err}, 8'h0);
        rst = 1'b1;
        cycles(2);

        // 1: 0x39 -> choice 3, dir 11, BT owns for 8 cycles
        push(0, 3'd3, 2'b11, 2'b01);
        send_byte(8'h39);
        chk("t1_owner_bt", {6'd0, bus.owner}, 8'h01);
        cycles(7);
        chk("t1_owner_before_release", {6'd0, bus.owner}, 8'h01);
        cycles(1);
        chk("t1_owner_released", {6'd0, bus.owner}, 8'h00);
        chk("t1_choice_held", {5'd0, bus.choice}, 8'h03);

        // 2: illegal bytes -> bt_err only
        push(1, 3'd3, 2'b11, 2'b00);
        send_byte(8'h50);
        push(1, 3'd3, 2'b11, 2'b00);
        send_byte(8'h80);
        cycles(1);
        chk("t2_owner", {6'd0, bus.owner}, 8'h00);
        chk("t2_dir", {6'd0, bus.dir}, 8'h03);

        // 3: key and BT in the same cycle -> BT wins
        push(0, 3'd2, 2'b00, 2'b01);
        @(posedge clk); #1;
        bus.key_req = 1'b1; bus.key_choice = 3'd4; bus.key_dir = 2'b01;
        bus.rx_data = 8'h21; bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.key_req = 1'b0;
        chk("t3_owner", {6'd0, bus.owner}, 8'h01);
        chk("t3_choice", {5'd0, bus.choice}, 8'h02);
        cycles(8);
        chk("t3_released", {6'd0, bus.owner}, 8'h00);

        // 4: key ownership, BT preemption, re-entry after timeout
        push(0, 3'd4, 2'b10, 2'b10);
        bus.key_req = 1'b1; bus.key_choice = 3'd4; bus.key_dir = 2'b10;
        cycles(1);
        chk("t4_owner_key", {6'd0, bus.owner}, 8'h02);
        push(0, 3'd1, 2'b00, 2'b01);
        push(0, 3'd4, 2'b10, 2'b10);
        send_byte(8'h11);
        chk("t4_owner_bt", {6'd0, bus.owner}, 8'h01);
        cycles(7);
        chk("t4_keys_ignored", {5'd0, bus.choice}, 8'h01);
        cycles(1);
        chk("t4_idle", {6'd0, bus.owner}, 8'h00);
        cycles(1);
        chk("t4_key_reenter", {6'd0, bus.owner}, 8'h02);
        push(0, 3'd2, 2'b10, 2'b10);
        bus.key_choice = 3'd2;
        cycles(1);
        chk("t4_key_track", {5'd0, bus.choice}, 8'h02);
        bus.key_req = 1'b0;
        cycles(1);
        chk("t4_key_release", {6'd0, bus.owner}, 8'h00);

        // 5: repeated identical byte -> one pulse, timer refreshed
        push(0, 3'd3, 2'b11, 2'b01);
        send_byte(8'h39);
        cycles(2);
        send_byte(8'h39);
        cycles(7);
        chk("t5_owner_before_release", {6'd0, bus.owner}, 8'h01);
        cycles(1);
        chk("t5_released", {6'd0, bus.owner}, 8'h00);

        // 6: async reset in the middle of BT ownership
        push(0, 3'd4, 2'b00, 2'b01);
        send_byte(8'h40);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_owner", {6'd0, bus.owner}, 8'h00);
        chk("t6_rst_outputs", {bus.choice, bus.dir, bus.cmd_valid, bus.bt_err}, 8'h00);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        chk("t6_resume_idle", {6'd0, bus.owner}, 8'h00);
        push(0, 3'd4, 2'b10, 2'b01);
        send_byte(8'h48);
        chk("t6_resume_bt", {6'd0, bus.owner}, 8'h01);

        cycles(3);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
